// File: rtl/mprj_io_cfg_serializer.sv
// Walks the per-pad config array farthest pad first, shifts each word MSB-first
// down the GPIO control-block chain, then strobes serial_load so all pads latch together.
module mprj_io_cfg_serializer #(
    parameter int NUM_IO   = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2,
    localparam int IDX_W   = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    output logic [IDX_W-1:0]    cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_rdata,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                busy,
    output logic                done
);

    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_PAD = IDX_W'(NUM_IO - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_BITS - 1);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_pad_idx;
    logic [BIT_W-1:0]    r_bit_idx;
    logic [PH_W-1:0]     r_ph_cnt;
    logic [CFG_BITS-1:0] r_shreg;
    logic                r_sclk;
    logic                r_sdo;
    logic                r_load;
    logic                r_busy;
    logic                r_done;

    logic                w_ph_last;
    logic [CFG_BITS-1:0] w_shreg_shl;

    assign w_ph_last   = (r_ph_cnt == LAST_PH);
    assign w_shreg_shl = r_shreg << 1;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_pad_idx <= LAST_PAD;
            r_bit_idx <= LAST_BIT;
            r_ph_cnt  <= '0;
            r_shreg   <= '0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_load    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= FETCH;
                        r_busy    <= 1'b1;
                        r_pad_idx <= LAST_PAD;
                        r_bit_idx <= LAST_BIT;
                    end
                end

                // cfg_addr is r_pad_idx itself, so cfg_rdata is valid this cycle
                FETCH: begin
                    r_shreg  <= cfg_rdata;
                    r_sdo    <= cfg_rdata[CFG_BITS-1];
                    r_ph_cnt <= '0;
                    r_state  <= SHIFT_LO;
                end

                SHIFT_LO: begin
                    if (w_ph_last) begin
                        r_ph_cnt <= '0;
                        r_sclk   <= 1'b1;
                        r_state  <= SHIFT_HI;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end

                // Next bit is presented together with the falling serial_clock edge
                SHIFT_HI: begin
                    if (w_ph_last) begin
                        r_ph_cnt <= '0;
                        r_sclk   <= 1'b0;
                        r_shreg  <= w_shreg_shl;
                        if (r_bit_idx != '0) begin
                            r_bit_idx <= r_bit_idx - BIT_W'(1);
                            r_sdo     <= w_shreg_shl[CFG_BITS-1];
                            r_state   <= SHIFT_LO;
                        end else if (r_pad_idx != '0) begin
                            r_pad_idx <= r_pad_idx - IDX_W'(1);
                            r_bit_idx <= LAST_BIT;
                            r_state   <= FETCH;
                        end else begin
                            r_load  <= 1'b1;
                            r_state <= LOAD;
                        end
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end

                LOAD: begin
                    if (w_ph_last) begin
                        r_ph_cnt  <= '0;
                        r_load    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pad_idx <= LAST_PAD;
                        r_state   <= IDLE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_sclk  <= 1'b0;
                    r_load  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_addr        = r_pad_idx;
    assign serial_clock    = r_sclk;
    assign serial_data_out = r_sdo;
    assign serial_load     = r_load;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule
